// File: rtl/fpu_result_buffer.sv
// Capture FIFO between the FPU and register writeback; entries are {opcode, tag, data}.
// Latency: one cycle finish-to-ovalid; zero with FPU_RESULT_BYPASS_EN while the buffer is empty.
// Backpressure: fpu_stall is high while full (registered state only); writeback drains via ovalid/oready.
module fpu_result_buffer #(
    parameter int N     = 32,
    parameter int L     = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fpu_finish,
    input  logic [N*L-1:0]           fpu_o,
    input  logic [5:0]               fpu_opcode,
    input  logic [TAG_W-1:0]         fpu_tag,
    output logic                     fpu_stall,
    output logic                     ovalid,
    input  logic                     oready,
    output logic [N*L-1:0]           odata,
    output logic [TAG_W-1:0]         otag,
    output logic [5:0]               oopcode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [5:0]       opcode;
        logic [TAG_W-1:0] tag;
        logic [N*L-1:0]   data;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            wr_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              stored_vld;
    logic              bypass_vld;
    logic              push;
    logic              pop;

    assign wr_entry   = '{opcode: fpu_opcode, tag: fpu_tag, data: fpu_o};
    assign stored_vld = (count_q != '0);
    assign fpu_stall  = (count_q == FULL_CNT);

`ifdef FPU_RESULT_BYPASS_EN
    assign bypass_vld = !stored_vld && fpu_finish;
`else
    assign bypass_vld = 1'b0;
`endif

    assign ovalid = stored_vld || bypass_vld;
    assign pop    = stored_vld && oready;
    // A bypassed result that writeback takes immediately never touches storage.
    assign push   = fpu_finish && !fpu_stall && !(bypass_vld && oready);

    // Outputs are forced to zero while empty so discarded entries never leak out.
    always_comb begin
        head = '0;
        if (stored_vld) begin
            head = mem[rd_ptr];
        end else if (bypass_vld) begin
            head = wr_entry;
        end
    end

    assign odata   = head.data;
    assign otag    = head.tag;
    assign oopcode = head.opcode;
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
